muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the pipelined MIPS CPU. Owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, then runs either a latency-counted multiply or a 32-iteration restoring divider.
- Raises `busy` so hazard logic stalls MFHI/MFLO and any new muldiv op until the result commits.
- Sits beside the ALU in EX. The ALU keeps the single-cycle ops.

---
 rtl/muldiv_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers.
// Define MULDIV_MADD_EN to add the MADD/MADDU accumulate ops (op 110/111).

module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    localparam logic [4:0] MulCnt = 5'(MUL_LAT - 1);
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMaddu = 3'b111;
    localparam logic [4:0] MaddCnt = 5'(MUL_LAT);
`endif

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        sgn_q, sgn_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef MULDIV_MADD_EN
    logic        acc_q, acc_d;
`endif

    logic        div_signed;
    logic [31:0] abs_a, abs_b;
    logic [63:0] ext_a, ext_b, product, mul_res;
    logic [32:0] rem_sh;
    logic        q_bit;

    always_comb begin
        // Low 64 bits of the extended product are exact for both signed and unsigned.
        ext_a   = sgn_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
        ext_b   = sgn_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
        product = ext_a * ext_b;
`ifdef MULDIV_MADD_EN
        mul_res = acc_q ? ({hi_q, lo_q} + product) : product;
`else
        mul_res = product;
`endif
        // Restoring step: opa_q shifts the dividend out and the quotient in.
        rem_sh     = {rem_q, opa_q[31]};
        q_bit      = (rem_sh >= {1'b0, opb_q});
        div_signed = ~op[0];
        abs_a      = (div_signed && busA[31]) ? -busA : busA;
        abs_b      = (div_signed && busB[31]) ? -busB : busB;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef MULDIV_MADD_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    case (op)
                        OpMthi: hi_d = busA;
                        OpMtlo: lo_d = busA;
                        OpMult, OpMultu: begin
                            opa_d   = busA;
                            opb_d   = busB;
                            sgn_d   = ~op[0];
                            cnt_d   = MulCnt;
                            busy_d  = 1'b1;
                            state_d = StMul;
`ifdef MULDIV_MADD_EN
                            acc_d   = 1'b0;
`endif
                        end
`ifdef MULDIV_MADD_EN
                        OpMadd, OpMaddu: begin
                            opa_d   = busA;
                            opb_d   = busB;
                            sgn_d   = ~op[0];
                            cnt_d   = MaddCnt;
                            busy_d  = 1'b1;
                            acc_d   = 1'b1;
                            state_d = StMul;
                        end
`endif
                        OpDiv, OpDivu: begin
                            busy_d = 1'b1;
                            if (busB == 32'd0) begin
                                opa_d     = '1;
                                rem_d     = busA;
                                neg_quo_d = 1'b0;
                                neg_rem_d = 1'b0;
                                state_d   = StFix;
                            end else begin
                                opa_d     = abs_a;
                                opb_d     = abs_b;
                                rem_d     = 32'd0;
                                neg_quo_d = div_signed & (busA[31] ^ busB[31]);
                                neg_rem_d = div_signed & busA[31];
                                cnt_d     = 5'd31;
                                state_d   = StDiv;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (cnt_q == 5'd0) begin
                    {hi_d, lo_d} = mul_res;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDiv: begin
                opa_d = {opa_q[30:0], q_bit};
                rem_d = q_bit ? 32'(rem_sh - {1'b0, opb_q}) : rem_sh[31:0];
                if (cnt_q == 5'd0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                lo_d    = neg_quo_q ? -opa_q : opa_q;
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase

        // A squash beats any commit on the same edge.
        if (flush && (state_q != StIdle)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            rem_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MULDIV_MADD_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver queues expected commits and idle snapshots,
// a negedge monitor compares them against the DUT.

module tb_muldiv_ctrl;

    localparam int unsigned MulLat = 4;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMaddu = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] busA = '0;
    logic [31:0] busB = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    muldiv_ctrl #(.MUL_LAT(MulLat)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .busA  (busA),
        .busB  (busB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hilo;
        int          lat;
        int          tag;
    } commit_t;

    typedef struct {
        logic [65:0] obs;
        int          tag;
    } probe_t;

    commit_t     exp_q[$];
    probe_t      probe_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          tag_n = 0;
    int          tmo_cnt = 0;
    int          tmo_seen = 0;
    int          cycles = 0;
    int          busy_cnt = 0;
    bit          stim_done = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    // Reference results straight from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              da, db;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            OpMult:  return sa * sb;
            OpMultu: return ua * ub;
            OpDiv: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                da = $signed(a);
                db = $signed(b);
                return {32'(da % db), 32'(da / db)};
            end
            OpDivu: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OpMadd:  return acc + sa * sb;
            OpMaddu: return acc + ua * ub;
            default: return acc;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] b);
        if (o == OpDiv || o == OpDivu) return (b == 32'd0) ? 1 : 33;
        if (o == OpMadd || o == OpMaddu) return MulLat + 1;
        return MulLat;
    endfunction

    function automatic bit is_mul_div(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
        return (o != OpMthi) && (o != OpMtlo);
`else
        return !o[2];
`endif
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    function automatic void check(input string name, input int tag, input logic [65:0] act,
                                  input logic [65:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s #%0d: got %h, required %h", name, tag, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) tmo_cnt++;
    endtask

    task automatic push_probe(input logic b, input logic d);
        probe_t p;
        p.obs = {b, d, m_hi, m_lo};
        p.tag = tag_n;
        tag_n++;
        probe_q.push_back(p);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        busA  = a;
        busB  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        commit_t c;
        wait_idle();
        if (is_mul_div(o)) begin
            c.hilo = model(o, a, b, {m_hi, m_lo});
            c.lat  = latency(o, b);
            c.tag  = tag_n;
            tag_n++;
            exp_q.push_back(c);
            {m_hi, m_lo} = c.hilo;
            drive(o, a, b);
        end else begin
            if (o == OpMthi) m_hi = a;
            else if (o == OpMtlo) m_lo = a;
            drive(o, a, b);
            push_probe(1'b0, 1'b0);
        end
    endtask

    // Flush lands on accept edge + k; k equal to the latency hits the commit edge.
    task automatic run_flush(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int k);
        wait_idle();
        drive(o, a, b);
        repeat (k - 1) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push_probe(1'b0, 1'b0);
    endtask

    initial begin
        commit_t c;
        probe_t  p;
        forever begin
            @(negedge clk);
            cycles++;
            if (tmo_seen != tmo_cnt) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_idle bound: busy still %b after 100 cycles, required 0", busy);
                tmo_seen = tmo_cnt;
            end
            if (probe_q.size() != 0) begin
                p = probe_q.pop_front();
                check("idle busy/done/hi/lo", p.tag, {busy, done, hi, lo}, p.obs);
            end
            if (done === 1'b1) begin
                check("done spacing", 0, 66'(prev_done), 66'd0);
                check("pending op at done", 0, 66'(exp_q.size() != 0), 66'd1);
                if (exp_q.size() != 0) begin
                    c = exp_q.pop_front();
                    check("commit hi/lo", c.tag, {2'b00, hi, lo}, {2'b00, c.hilo});
                    check("busy cycles", c.tag, 66'(busy_cnt), 66'(c.lat));
                end
            end
            prev_done = done;
            busy_cnt  = (busy === 1'b1) ? busy_cnt + 1 : 0;
            if (stim_done) begin
                check("ops left uncommitted", 0, 66'(exp_q.size()), 66'd0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
            if (cycles > 40000) begin
                miscompares++;
                $display("FAIL watchdog: %0d cycles elapsed, required under 40000", cycles);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        rst_n = 1'b0;
        tick();
        tick();
        push_probe(1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        do_op(OpMult, 32'hFFFF_FFFE, 32'd3);
        do_op(OpMultu, 32'hFFFF_FFFE, 32'd3);
        do_op(OpDiv, 32'hFFFF_FFF9, 32'd2);
        do_op(OpDivu, 32'd100, 32'd7);
        do_op(OpDivu, 32'h0000_1234, 32'd0);
        do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);

        do_op(OpMthi, 32'hAAAA_5555, 32'd0);
        do_op(OpMtlo, 32'h0F0F_0F0F, 32'd0);
        // A second op offered while busy must be dropped.
        do_op(OpMult, 32'd1234, 32'd5678);
        tick();
        drive(OpDivu, 32'd9, 32'd3);
        wait_idle();
        repeat (3) tick();
        push_probe(1'b0, 1'b0);

        do_op(OpMthi, 32'd1, 32'd0);
        do_op(OpMtlo, 32'd2, 32'd0);
        run_flush(OpMult, 32'd5, 32'd5, 2);
        run_flush(OpMult, 32'd5, 32'd5, MulLat);
        run_flush(OpDiv, 32'd77, 32'd5, 33);
        wait_idle();
        flush = 1'b1;
        drive(OpMthi, 32'hDEAD_BEEF, 32'd0);
        flush = 1'b0;
        push_probe(1'b0, 1'b0);

        wait_idle();
        drive(OpDiv, 32'd1000, 32'd3);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        push_probe(1'b0, 1'b0);

`ifdef MULDIV_MADD_EN
        do_op(OpMthi, 32'd0, 32'd0);
        do_op(OpMtlo, 32'hFFFF_FFFF, 32'd0);
        do_op(OpMaddu, 32'd1, 32'd1);
        do_op(OpMadd, 32'hFFFF_FFFF, 32'd3);
`else
        do_op(OpMtlo, 32'h1357_9BDF, 32'd0);
        do_op(OpMadd, 32'd7, 32'd9);
        do_op(OpMaddu, 32'd1, 32'd1);
`endif

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_word();
            b = rnd_word();
            do_op(o, a, b);
        end
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            a = rnd_word();
            b = rnd_word();
            run_flush(o, a, b, $urandom_range(1, latency(o, b)));
            do_op(3'($urandom_range(0, 7)), rnd_word(), rnd_word());
        end

        wait_idle();
        repeat (3) tick();
        stim_done = 1'b1;
    end

endmodule
